accel_bus0_arbiter: RTL

Round-robin read/write arbiter for the accelerator AXI4 bus0 interconnect. Replaces the fixed "highest index wins" master selection with fair, registered grants. Each channel is locked to one master from address handshake until its transaction completes. Sits beside the bus0 crossbar: it takes master valids and slave handshake events, and drives the master indices the crossbar muxes on. A per-channel timeout releases a hung slave and counts the event.

---
 rtl/accel_bus0_arbiter_pkg.sv | 40 ++++
 rtl/accel_bus0_arbiter_if.sv | 35 +++
 rtl/accel_bus0_arbiter_ch.sv | 111 +++++++++++
 rtl/accel_bus0_arbiter.sv | 47 ++++
 4 files changed

// File: rtl/accel_bus0_arbiter_pkg.sv
// Shared types, reset value and defaults for the bus0 round-robin arbiter.
// Index fields are ARB_IDX_W bits wide, which covers up to seven masters plus the "none" index.
package accel_bus0_arbiter_pkg;

  localparam int ARB_TIMEOUT_DFLT = 1024;
  localparam int ARB_NMST_DFLT    = 4;
  localparam int ARB_IDX_W        = 3;
  localparam int ARB_WDOG_W       = 16;
  localparam int ARB_CNT_W        = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state_e;

  typedef struct packed {
    arb_state_e             state;
    logic [ARB_IDX_W-1:0]   ptr;
    logic [ARB_IDX_W-1:0]   midx;
    logic [ARB_WDOG_W-1:0]  wdog;
    logic [ARB_CNT_W-1:0]   err_cnt;
  } arb_ch_t;

  localparam arb_ch_t ARB_CH_RST = '{
    state:   ARB_IDLE,
    ptr:     '0,
    midx:    ARB_IDX_W'(ARB_NMST_DFLT),
    wdog:    '0,
    err_cnt: '0
  };

  // Round-robin successor of a master index, wrapping at nmst.
  function automatic logic [ARB_IDX_W-1:0] arb_next_idx(input logic [ARB_IDX_W-1:0] idx,
                                                         input int nmst);
    if (int'(idx) + 1 >= nmst) return '0;
    return idx + ARB_IDX_W'(1);
  endfunction

endpackage

// File: rtl/accel_bus0_arbiter_if.sv
// Handshake bundle between the bus0 crossbar and its arbiter.
// The slave modport is the arbiter side; master is the crossbar side.
interface accel_bus0_arbiter_if #(
  parameter int NMST   = 4,
  parameter int MIDX_W = 3
);

  logic [NMST-1:0]   i_ar_valid;
  logic              i_ar_fire;
  logic              i_r_done;
  logic [NMST-1:0]   i_aw_valid;
  logic              i_aw_fire;
  logic              i_b_done;
  logic [MIDX_W-1:0] o_ar_midx;
  logic              o_ar_gnt;
  logic [MIDX_W-1:0] o_aw_midx;
  logic              o_aw_gnt;
  logic              o_rd_timeout;
  logic              o_wr_timeout;
  logic [15:0]       o_rd_err_cnt;
  logic [15:0]       o_wr_err_cnt;

  modport slave (
    input  i_ar_valid, i_ar_fire, i_r_done, i_aw_valid, i_aw_fire, i_b_done,
    output o_ar_midx, o_ar_gnt, o_aw_midx, o_aw_gnt,
           o_rd_timeout, o_wr_timeout, o_rd_err_cnt, o_wr_err_cnt
  );

  modport master (
    output i_ar_valid, i_ar_fire, i_r_done, i_aw_valid, i_aw_fire, i_b_done,
    input  o_ar_midx, o_ar_gnt, o_aw_midx, o_aw_gnt,
           o_rd_timeout, o_wr_timeout, o_rd_err_cnt, o_wr_err_cnt
  );

endinterface

// File: rtl/accel_bus0_arbiter_ch.sv
// One arbitration channel: round-robin pick in IDLE, owner locked through ADDR and DATA,
// watchdog forces release of a hung slave and counts the event.
module accel_bus0_arbiter_ch
  import accel_bus0_arbiter_pkg::*;
#(
  parameter int NMST    = 4,
  parameter int MIDX_W  = 3,
  parameter int TIMEOUT = ARB_TIMEOUT_DFLT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NMST-1:0]      i_valid,
  input  logic                 i_fire,
  input  logic                 i_done,
  output logic [MIDX_W-1:0]    o_midx,
  output logic                 o_gnt,
  output logic                 o_timeout,
  output logic [ARB_CNT_W-1:0] o_err_cnt
);

  localparam logic [ARB_IDX_W-1:0]  IDX_NONE  = ARB_IDX_W'(NMST);
  localparam logic [ARB_WDOG_W-1:0] WDOG_LAST = ARB_WDOG_W'(TIMEOUT - 1);

  arb_ch_t ch_q, ch_d;
  logic    timeout_q, timeout_d;

  logic [2**ARB_IDX_W-1:0] valid_ext;
  logic                    found;
  logic [ARB_IDX_W-1:0]    winner;
  logic                    release_req;

  // Scan valids starting at ptr; the padded vector lets the scan index address any bit.
  always_comb begin
    logic [ARB_IDX_W-1:0] scan_idx;
    valid_ext = '0;
    valid_ext[NMST-1:0] = i_valid;
    found    = 1'b0;
    winner   = '0;
    scan_idx = ch_q.ptr;
    for (int k = 0; k < NMST; k++) begin
      if (!found && valid_ext[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
      scan_idx = arb_next_idx(scan_idx, NMST);
    end
  end

  always_comb begin
    ch_d        = ch_q;
    timeout_d   = 1'b0;
    release_req = 1'b0;
    unique case (ch_q.state)
      ARB_IDLE: begin
        if (found) begin
          ch_d.state = ARB_ADDR;
          ch_d.midx  = winner;
          ch_d.wdog  = '0;
        end
      end
      ARB_ADDR: begin
        if (i_fire) begin
          ch_d.state = ARB_DATA;
          ch_d.wdog  = '0;
        end else if (ch_q.wdog == WDOG_LAST) begin
          timeout_d = 1'b1;
        end else begin
          ch_d.wdog = ch_q.wdog + ARB_WDOG_W'(1);
        end
      end
      ARB_DATA: begin
        if (i_done) begin
          release_req = 1'b1;
        end else if (ch_q.wdog == WDOG_LAST) begin
          timeout_d = 1'b1;
        end else begin
          ch_d.wdog = ch_q.wdog + ARB_WDOG_W'(1);
        end
      end
      default: ch_d = ch_q;
    endcase

    // Normal and forced releases both hand priority to the master after the owner.
    if (release_req || timeout_d) begin
      ch_d.state = ARB_IDLE;
      ch_d.midx  = IDX_NONE;
      ch_d.ptr   = arb_next_idx(ch_q.midx, NMST);
      ch_d.wdog  = '0;
    end
    if (timeout_d && (ch_q.err_cnt != '1)) begin
      ch_d.err_cnt = ch_q.err_cnt + ARB_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ch_q      <= ARB_CH_RST;
      ch_q.midx <= IDX_NONE;
      timeout_q <= 1'b0;
    end else begin
      ch_q      <= ch_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_midx    = MIDX_W'(ch_q.midx);
  assign o_gnt     = (ch_q.state == ARB_ADDR);
  assign o_timeout = timeout_q;
  assign o_err_cnt = ch_q.err_cnt;

endmodule

// File: rtl/accel_bus0_arbiter.sv
// Bus0 arbiter top: independent read (ar/r) and write (aw/b) round-robin channels.
// Write data follows o_aw_midx, so the write channel stays locked until the B response.
module accel_bus0_arbiter
  import accel_bus0_arbiter_pkg::*;
#(
  parameter int NMST    = 4,
  parameter int MIDX_W  = 3,
  parameter int TIMEOUT = ARB_TIMEOUT_DFLT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  accel_bus0_arbiter_if.slave  bus
);

  accel_bus0_arbiter_ch #(
    .NMST    (NMST),
    .MIDX_W  (MIDX_W),
    .TIMEOUT (TIMEOUT)
  ) u_rd_ch (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (bus.i_ar_valid),
    .i_fire    (bus.i_ar_fire),
    .i_done    (bus.i_r_done),
    .o_midx    (bus.o_ar_midx),
    .o_gnt     (bus.o_ar_gnt),
    .o_timeout (bus.o_rd_timeout),
    .o_err_cnt (bus.o_rd_err_cnt)
  );

  accel_bus0_arbiter_ch #(
    .NMST    (NMST),
    .MIDX_W  (MIDX_W),
    .TIMEOUT (TIMEOUT)
  ) u_wr_ch (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (bus.i_aw_valid),
    .i_fire    (bus.i_aw_fire),
    .i_done    (bus.i_b_done),
    .o_midx    (bus.o_aw_midx),
    .o_gnt     (bus.o_aw_gnt),
    .o_timeout (bus.o_wr_timeout),
    .o_err_cnt (bus.o_wr_err_cnt)
  );

endmodule
